// File: rtl/iq_entry_buffer_pkg.sv
// Shared issue-queue definitions used by the counter, the entry buffer and dispatch.
// Counts are byte-wide so they line up with the counter's occupancy bytes.
package iq_pkg;

    localparam int IQ_CNT_W    = 8;
    localparam int IQ_DATA_W   = 32;
    localparam int IQ_CAPACITY = 8;
    localparam int IQ_MAX_IN   = 4;

    typedef logic [IQ_CNT_W-1:0]  iq_count_t;
    typedef logic [IQ_DATA_W-1:0] iq_entry_t;

    function automatic iq_count_t minCount(input iq_count_t a, input iq_count_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/iq_entry_buffer_slot_mux.sv
// Next-value select for one buffer slot: hold, shift down from the slot above,
// take an incoming lane, or clear when the slot falls beyond the new occupancy.
module iq_slot_mux
    import iq_pkg::*;
#(
    parameter int SLOT_IDX = 0,
    parameter int MAX_IN   = IQ_MAX_IN,
    parameter int DATA_W   = IQ_DATA_W,
    parameter int CNT_W    = IQ_CNT_W
) (
    input  logic [CNT_W-1:0]         afterSend,
    input  logic                     popped,
    input  logic [CNT_W-1:0]         numIn,
    input  logic [DATA_W-1:0]        curData,
    input  logic [DATA_W-1:0]        aboveData,
    input  logic [MAX_IN*DATA_W-1:0] laneData,
    output logic [DATA_W-1:0]        nextData
);

    localparam logic [CNT_W-1:0] IDX = CNT_W'(SLOT_IDX);

    logic [CNT_W-1:0] laneOff;

    always_comb begin
        nextData = '0;
        laneOff  = IDX - afterSend;
        if (IDX < afterSend) begin
            nextData = popped ? aboveData : curData;
        end else if (laneOff < numIn) begin
            // Lane k lands at slot afterSend + k, so the lane is the offset from afterSend.
            for (int k = 0; k < MAX_IN; k++) begin
                if (laneOff == CNT_W'(k)) begin
                    nextData = laneData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/iq_entry_buffer.sv
// Age-ordered entry storage for the issue queue (slot 0 = oldest). Applies kills,
// pops the head, appends upstream deliveries and reports registered occupancy.
module iq_entry_buffer
    import iq_pkg::*;
#(
    parameter int CAPACITY = IQ_CAPACITY,
    parameter int MAX_IN   = IQ_MAX_IN,
    parameter int DATA_W   = IQ_DATA_W,
    parameter int CNT_W    = IQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     kill_all,
    input  logic [CNT_W-1:0]         kill,
    input  logic                     sending,
    input  logic [CNT_W-1:0]         accepting,
    input  logic [CNT_W-1:0]         prev_sending,
    input  logic [MAX_IN*DATA_W-1:0] in_data,
    output logic [CNT_W-1:0]         full,
    output logic                     head_valid,
    output logic [DATA_W-1:0]        head_data,
    output logic                     proto_err
);

    localparam iq_count_t CAP_C   = IQ_CNT_W'(CAPACITY);
    localparam iq_count_t MAXIN_C = IQ_CNT_W'(MAX_IN);

    logic [DATA_W-1:0] slotsReg  [CAPACITY];
    logic [DATA_W-1:0] slotsNext [CAPACITY];
    logic [DATA_W-1:0] aboveData [CAPACITY];

    iq_count_t fullReg;
    iq_count_t fullNext;
    iq_count_t living;
    iq_count_t afterSend;
    iq_count_t room;
    iq_count_t numIn;
    logic      popped;
    logic      errNow;
    logic      protoErrReg;

    // Kill first, then pop, then append into whatever room is left.
    always_comb begin
        living = '0;
        if (!kill_all && (kill < fullReg)) begin
            living = fullReg - kill;
        end
        popped    = sending && (living != '0);
        afterSend = living - {{(IQ_CNT_W-1){1'b0}}, popped};
        room      = CAP_C - afterSend;
        numIn     = minCount(minCount(prev_sending, MAXIN_C), room);
        fullNext  = afterSend + numIn;
        errNow    = (kill > fullReg)
                  | (sending && (living == '0))
                  | (prev_sending > accepting)
                  | (prev_sending > MAXIN_C)
                  | (prev_sending > room);
    end

    genvar gi;
    generate
        for (gi = 0; gi < CAPACITY; gi++) begin : g_slot
            if (gi == CAPACITY - 1) begin : g_top
                assign aboveData[gi] = '0;
            end else begin : g_mid
                assign aboveData[gi] = slotsReg[gi+1];
            end

            iq_slot_mux #(
                .SLOT_IDX (gi),
                .MAX_IN   (MAX_IN),
                .DATA_W   (DATA_W),
                .CNT_W    (IQ_CNT_W)
            ) u_mux (
                .afterSend (afterSend),
                .popped    (popped),
                .numIn     (numIn),
                .curData   (slotsReg[gi]),
                .aboveData (aboveData[gi]),
                .laneData  (in_data),
                .nextData  (slotsNext[gi])
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slotsReg[gi] <= '0;
                end else begin
                    slotsReg[gi] <= slotsNext[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fullReg     <= '0;
            protoErrReg <= 1'b0;
        end else begin
            fullReg     <= fullNext;
            protoErrReg <= protoErrReg | errNow;
        end
    end

    // Slots beyond the occupancy are cleared, so slot 0 already reads zero when empty.
    assign full       = fullReg;
    assign head_valid = (fullReg != '0);
    assign head_data  = slotsReg[0];
    assign proto_err  = protoErrReg;

endmodule

// File: tb/tb_iq_entry_buffer.sv
// Scoreboard bench for iq_entry_buffer: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_iq_entry_buffer;

    localparam int CAPACITY = 8;
    localparam int MAX_IN   = 4;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     kill_all;
    logic [CNT_W-1:0]         kill;
    logic                     sending;
    logic [CNT_W-1:0]         accepting;
    logic [CNT_W-1:0]         prev_sending;
    logic [MAX_IN*DATA_W-1:0] in_data;
    logic [CNT_W-1:0]         full;
    logic                     head_valid;
    logic [DATA_W-1:0]        head_data;
    logic                     proto_err;

    iq_entry_buffer #(
        .CAPACITY (CAPACITY),
        .MAX_IN   (MAX_IN),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kill_all     (kill_all),
        .kill         (kill),
        .sending      (sending),
        .accepting    (accepting),
        .prev_sending (prev_sending),
        .in_data      (in_data),
        .full         (full),
        .head_valid   (head_valid),
        .head_data    (head_data),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               tag;
        logic [CNT_W-1:0] full;
        logic             hv;
        logic [DATA_W-1:0] hd;
        logic             err;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] mq[$];
    logic              merr;
    int                checks;
    int                errors;
    int                txn;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [MAX_IN*DATA_W-1:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Reference model: the buffer is a plain queue; each cycle kill, pop, then append.
    task automatic issue(input logic r, input logic ka, input int k, input logic s,
                         input int acc, input int ps, input logic [MAX_IN*DATA_W-1:0] lanes);
        exp_t e;
        int   living;
        int   room;
        int   n;
        @(negedge clk);
        rst_n        = r;
        kill_all     = ka;
        kill         = k[CNT_W-1:0];
        sending      = s;
        accepting    = acc[CNT_W-1:0];
        prev_sending = ps[CNT_W-1:0];
        in_data      = lanes;
        if (!r) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            if (k > mq.size()) merr = 1'b1;
            living = ka ? 0 : ((k >= mq.size()) ? 0 : mq.size() - k);
            while (mq.size() > living) void'(mq.pop_back());
            if (s) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else merr = 1'b1;
            end
            room = CAPACITY - mq.size();
            if (ps > acc || ps > MAX_IN || ps > room) merr = 1'b1;
            n = imin(imin(ps, MAX_IN), room);
            for (int i = 0; i < n; i++) mq.push_back(lanes[i*DATA_W +: DATA_W]);
        end
        e.tag  = txn;
        e.full = CNT_W'(mq.size());
        e.hv   = (mq.size() != 0);
        e.hd   = (mq.size() != 0) ? mq[0] : '0;
        e.err  = merr;
        txn++;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: each issued cycle produces one expected output state after its edge.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            checks += 4;
            if (full !== me.full) begin
                errors++;
                $display("FAIL txn %0d full: got %0d expected %0d", me.tag, full, me.full);
            end
            if (head_valid !== me.hv) begin
                errors++;
                $display("FAIL txn %0d head_valid: got %b expected %b", me.tag, head_valid, me.hv);
            end
            if (head_data !== me.hd) begin
                errors++;
                $display("FAIL txn %0d head_data: got %h expected %h", me.tag, head_data, me.hd);
            end
            if (proto_err !== me.err) begin
                errors++;
                $display("FAIL txn %0d proto_err: got %b expected %b", me.tag, proto_err, me.err);
            end
            $display("txn %0d: full=%0d head_valid=%b head_data=%h proto_err=%b",
                     me.tag, full, head_valid, head_data, proto_err);
        end
    end

    localparam logic [31:0] A = 32'h0000_000A, B = 32'h0000_000B, C = 32'h0000_000C;
    localparam logic [31:0] D = 32'h0000_000D, E = 32'h0000_000E, F = 32'h0000_000F;
    localparam logic [31:0] G = 32'h0000_0010, X = 32'h0000_0058;
    localparam logic [31:0] P = 32'h0000_0050, Q = 32'h0000_0051;

    initial begin
        int sz, k, living, after, room, acc, ps;
        logic ka, s, r;
        checks = 0; errors = 0; txn = 0; merr = 1'b0;
        rst_n = 1'b0; kill_all = 1'b0; kill = '0; sending = 1'b0;
        accepting = '0; prev_sending = '0; in_data = '0;

        // Reset, fill, drain
        issue(0, 0, 0, 0, 0, 0, '0);
        issue(1, 0, 0, 0, 4, 3, pack4(A, B, C, 0));
        issue(1, 0, 0, 0, 4, 4, pack4(D, E, F, G));
        repeat (3) issue(1, 0, 0, 1, 0, 0, '0);

        // Partial kill together with send and an arrival; then drain to expose B, C, X
        issue(0, 0, 0, 0, 0, 0, '0);
        issue(1, 0, 0, 0, 4, 3, pack4(A, B, C, 0));
        issue(1, 0, 0, 0, 4, 2, pack4(D, E, 0, 0));
        issue(1, 0, 2, 1, 4, 1, pack4(X, 0, 0, 0));
        repeat (3) issue(1, 0, 0, 1, 0, 0, '0);

        // Kill-all with arrivals
        issue(0, 0, 0, 0, 0, 0, '0);
        issue(1, 0, 0, 0, 4, 4, pack4(A, B, C, D));
        issue(1, 0, 0, 0, 4, 2, pack4(E, F, 0, 0));
        issue(1, 1, 0, 0, 4, 2, pack4(P, Q, 0, 0));

        // Overflow clamp, sticky error, then reset while sending with full=5
        issue(0, 0, 0, 0, 0, 0, '0);
        issue(1, 0, 0, 0, 4, 4, pack4(A, B, C, D));
        issue(1, 0, 0, 0, 4, 3, pack4(E, F, G, 0));
        issue(1, 0, 0, 0, 1, 3, pack4(X, P, Q, 0));
        repeat (2) issue(1, 0, 0, 0, 0, 0, '0);
        issue(1, 0, 3, 0, 0, 0, '0);
        issue(0, 0, 0, 1, 0, 0, '0);
        issue(1, 0, 0, 0, 0, 0, '0);

        // Random traffic, mostly protocol-legal with occasional violations
        for (int t = 0; t < 600; t++) begin
            sz  = mq.size();
            r   = ($urandom_range(0, 49) != 0);
            ka  = ($urandom_range(0, 19) == 0);
            k   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sz) : 0;
            living = ka ? 0 : sz - k;
            s   = (living > 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            after = living - (s ? 1 : 0);
            room  = CAPACITY - after;
            acc   = $urandom_range(0, MAX_IN);
            ps    = $urandom_range(0, imin(acc, room));
            if ($urandom_range(0, 32) == 0) begin
                k  = $urandom_range(0, CAPACITY + 2);
                s  = $urandom_range(0, 1);
                ps = $urandom_range(0, 7);
            end
            issue(r, ka, k, s, acc, ps, {$urandom, $urandom, $urandom, $urandom});
        end

        @(negedge clk);
        rst_n = 1'b1; kill_all = 1'b0; kill = '0; sending = 1'b0; prev_sending = '0;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
